// File: rtl/arinc429_rx_if.sv
// arinc429_rx_if: line pins, display select and decoded-word status of the ARINC 429 receiver
interface arinc429_rx_if;
  logic        RXA;
  logic        RXB;
  logic        sel;
  logic [7:0]  label_sel;
  logic [31:0] word;
  logic [15:0] dat;
  logic        ce_wrd;
  logic        err_par;
  logic        err_frm;
  logic [4:0]  bit_cnt;
  modport master (output RXA, RXB, sel, label_sel, input word, dat, ce_wrd, err_par, err_frm, bit_cnt);
  modport slave (input RXA, RXB, sel, label_sel, output word, dat, ce_wrd, err_par, err_frm, bit_cnt);
endinterface

// File: rtl/arinc429_rx.sv
// arinc429_rx: bipolar RZ line decoder with glitch filter, parity/framing checks and 16-bit display mux.
// Define ARINC_RX_LABEL_FILTER_EN to accept only words whose label equals label_sel.
module arinc429_rx #(
  parameter int Fclk = 50000,
  parameter int Fbit = 100,
  parameter int FILT = 4
) (
  input  logic           clk,
  input  logic           rst,
  arinc429_rx_if.slave   bus
);
  localparam int GAP_CLK = 2 * Fclk / Fbit;
  localparam int NW = $clog2(GAP_CLK + 1);
  localparam int FW = $clog2(FILT + 1);
  // line levels encoded as {A,B}
  localparam logic [1:0] L_NULL = 2'b00, L_ONE = 2'b10, L_ILL = 2'b11;
  typedef enum logic [1:0] {GAP, IDLE, PULSE} state_t;
  logic [1:0]    s1_q, s2_q, cand_q, lev_q;
  logic [FW-1:0] fcnt_q;
  logic          ev_q;
  logic [NW-1:0] ncnt_q;
  state_t        st_q;
  logic [30:0]   sr_q;
  logic [31:0]   word_q, sr32;
  logic [4:0]    bcnt_q;
  logic          ce_q, par_q, frm_q;
  logic          bit_in, to_ev, accept;
  assign bit_in = lev_q == L_ONE;
  assign sr32   = {bit_in, sr_q};
  assign to_ev  = lev_q == L_NULL && ncnt_q == NW'(GAP_CLK - 1);
`ifdef ARINC_RX_LABEL_FILTER_EN
  assign accept = ^sr32 && sr32[7:0] == bus.label_sel;
`else
  logic unused_label;
  assign unused_label = ^bus.label_sel;
  assign accept = ^sr32;
`endif
  // ev_q flags a newly qualified level that differs from the previous one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= L_NULL;
      s2_q   <= L_NULL;
      cand_q <= L_NULL;
      fcnt_q <= '0;
      lev_q  <= L_NULL;
      ev_q   <= 1'b0;
      ncnt_q <= '0;
    end else begin
      s1_q   <= {bus.RXA, bus.RXB};
      s2_q   <= s1_q;
      ev_q   <= 1'b0;
      ncnt_q <= lev_q != L_NULL ? '0 : ncnt_q == NW'(GAP_CLK) ? ncnt_q : ncnt_q + 1'b1;
      if (s2_q != cand_q) begin
        cand_q <= s2_q;
        fcnt_q <= FW'(1);
      end else if (fcnt_q < FW'(FILT)) begin
        fcnt_q <= fcnt_q + 1'b1;
        if (fcnt_q == FW'(FILT - 1) && cand_q != lev_q) begin
          lev_q <= cand_q;
          ev_q  <= 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= GAP;
      sr_q   <= '0;
      word_q <= '0;
      bcnt_q <= '0;
      ce_q   <= 1'b0;
      par_q  <= 1'b0;
      frm_q  <= 1'b0;
    end else begin
      ce_q  <= 1'b0;
      frm_q <= 1'b0;
      if (ev_q && lev_q == L_ILL) begin
        frm_q  <= 1'b1;
        bcnt_q <= '0;
        st_q   <= GAP;
      end else begin
        case (st_q)
          GAP: if (to_ev) begin
            st_q   <= IDLE;
            bcnt_q <= '0;
          end
          IDLE: if (ev_q) begin
            bcnt_q <= bcnt_q + 1'b1;
            st_q   <= PULSE;
            if (bcnt_q == 5'd31) begin
              par_q <= ~^sr32;
              if (accept) begin
                word_q <= sr32;
                ce_q   <= 1'b1;
              end
            end else sr_q[bcnt_q] <= bit_in;
          end else if (to_ev && bcnt_q != 5'd0) begin
            frm_q  <= 1'b1;
            bcnt_q <= '0;
          end
          PULSE: if (ev_q) begin
            if (lev_q == L_NULL) st_q <= IDLE;
            else begin
              frm_q  <= 1'b1;
              bcnt_q <= '0;
              st_q   <= GAP;
            end
          end
          default: st_q <= GAP;
        endcase
      end
    end
  end
  assign bus.word    = word_q;
  assign bus.dat     = bus.sel ? word_q[31:16] : word_q[15:0];
  assign bus.ce_wrd  = ce_q;
  assign bus.err_par = par_q;
  assign bus.err_frm = frm_q;
  assign bus.bit_cnt = bcnt_q;
endmodule

// File: doc/arinc429_rx.md
# arinc429_rx

ARINC 429 receive front end that decodes the bipolar return-to-zero line into 32-bit words. It checks odd parity and framing, and presents a 16-bit half of the last good word on `dat` for the 4-digit hex display stage downstream. It sits between the line-receiver pins (HI/LO comparator outputs) and the display and status logic. It runs on the 50 MHz board clock.

## Interface
Parameters:
- `Fclk`, 50000: clock frequency in kHz.
- `Fbit`, 100: line bit rate in kbit/s; 12.5 kbit/s is set as `Fbit`=12 with `Fclk` scaled by the integrator.
- `FILT`, 4: consecutive synchronized samples required to qualify a line level.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `RXA` in 1: line HI comparator output; asynchronous.
- `RXB` in 1: line LO comparator output; asynchronous.
- `sel` in 1: display half select. 0 gives `word[15:0]`; 1 gives `word[31:16]`.
- `label_sel` in 8: label match value; used only with `ARINC_RX_LABEL_FILTER_EN`.
- `word` out 32: last accepted word; bit 0 is the first bit received.
- `dat` out 16: display data, selected by `sel` from `word`.
- `ce_wrd` out 1: one-clock strobe when `word` updates.
- `err_par` out 1: parity result of the last complete word; 1 means the parity was even (bad).
- `err_frm` out 1: one-clock strobe on a framing error.
- `bit_cnt` out 5: number of bits received in the current word.

## Operation
Line qualification:
- `RXA` and `RXB` each pass through a 2-flop synchronizer.
- The line state is one of ONE (A=1, B=0), ZERO (A=0, B=1), NULL (0, 0) or ILL (1, 1).
- A state is qualified after `FILT` identical consecutive samples. Shorter excursions are ignored.

FSM, three states (reset state GAP):
- GAP: wait for qualified NULL lasting `GAP_CLK = 2*Fclk/Fbit` clocks. Then go to IDLE with `bit_cnt`=0.
- IDLE (NULL between bits):
  - Qualified ONE or ZERO: shift the bit into `sr[bit_cnt]`, increment `bit_cnt`, go to PULSE.
  - Null counter reaching `GAP_CLK` with `bit_cnt`≠0: pulse `err_frm`, clear `bit_cnt`, stay in IDLE.
  - Null counter reaching `GAP_CLK` with `bit_cnt`=0: no action.
- PULSE: wait for qualified NULL, then go to IDLE and restart the null counter.
  - ONE↔ZERO with no intervening NULL: framing error. Pulse `err_frm`, drop the word, go to GAP.
- Qualified ILL in any state: pulse `err_frm`, drop the word, go to GAP.

Word completion:
- Acceptance of the 32nd bit completes the word, and `bit_cnt` wraps to 0.
- `err_par` is updated with `~^sr32` (the reduction XNOR of all 32 bits) on every complete word.
- `word` loads and `ce_wrd` pulses only when parity is odd. With even parity, `word` holds its value and `err_par` is 1.
- Back-to-back words need no gap: the bit after the 32nd starts a new word.
- `dat` is combinational from `word` and `sel`.

## Timing
- Reset values: `word`=0, `dat`=0, `ce_wrd`=0, `err_par`=0, `err_frm`=0, `bit_cnt`=0, FSM=GAP, all counters 0.
- Pin-to-qualify latency: 2 synchronizer clocks plus `FILT` clocks, i.e. 6 clocks at default.
- `ce_wrd`, `word`, `err_par`:
  - `ce_wrd` is high exactly 1 clock, on the edge after the 32nd bit qualifies.
  - `word` is valid from that same edge.
  - `err_par` updates on that same edge.
- `err_frm` is high for exactly 1 clock per event. A timeout and an ILL on the same clock produce a single pulse.
- Null counter: saturates at `GAP_CLK`; clears on any qualified non-NULL state.
- `rst` asserted mid-word: everything returns to reset values immediately. At least one full gap is needed before the next word is accepted.
- `sel` change: `dat` follows in the same cycle, since it is combinational.

## Configuration
- `ARINC_RX_LABEL_FILTER_EN` defined: `word` loads and `ce_wrd` pulses only if parity is good and `sr[7:0] == label_sel`. Non-matching good words are discarded silently; `err_par` still updates.
- Not defined: `label_sel` is ignored, and every good word is accepted.

## Test plan
- Default parameters: 500 clocks per bit, 250 clocks high. After a 1000-clock null, send 0x000000F1 (5 ones, odd) → one `ce_wrd` pulse; `word`=0x000000F1; `err_par`=0; with `sel`=0, `dat`=0x00F1.
- Send 0x800000F1 (6 ones) → no `ce_wrd`; `word` stays 0x000000F1; `err_par`=1.
- Send 10 bits, then hold NULL for 1000 clocks → `err_frm` pulses once; `bit_cnt` returns to 0; no `ce_wrd`. The next full word is accepted normally.
- Insert 3-clock glitches on `RXA` during the null phases of a valid word → the glitches are ignored; the word is received intact.
- Assert `rst` at bit 20, then release it and send a word immediately without a gap → the word is not accepted. After a 1000-clock gap, the next word 0x12345678 with its parity bit corrected is accepted; `sel`=1 gives `dat`=0x1234.
- With `ARINC_RX_LABEL_FILTER_EN` and `label_sel`=0xF1: send good words with label 0xF1 and label 0x0A → only the 0xF1 word gives `ce_wrd`.
